// File: rtl/xaui_rx_link_sync.sv
// Per-port XAUI receive synchroniser: per-lane code-sync FSMs feeding an ||A|| deskew/alignment FSM.
// Latency: input cycle n appears on outputs at n+2. No backpressure; consumes one column group every cycle.
module xaui_rx_link_sync #(
  parameter int unsigned COMMA_COUNT     = 4,
  parameter int unsigned BAD_CODE_LIMIT  = 4,
  parameter int unsigned GOOD_RUN        = 4,
  parameter int unsigned ALIGN_COUNT     = 4,
  parameter int unsigned ALIGN_ERR_LIMIT = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             xaui_clk,
  input  logic             xaui_rst_n,
  input  logic [63:0]      mgt_rxdata,
  input  logic [7:0]       mgt_rxcharisk,
  input  logic [7:0]       mgt_rxcodevalid,
  input  logic [3:0]       mgt_rxbufferr,
  output logic [3:0]       mgt_rxencommaalign,
  output logic             mgt_rxenchansync,
  output logic [3:0]       lane_sync,
  output logic             align_status,
  output logic             link_up,
  output logic [CNT_W-1:0] code_err_cnt,
  output logic [CNT_W-1:0] align_loss_cnt
);

  typedef enum logic {L_LOSS, L_SYNC} lane_st_e;
  typedef enum logic {A_LOSS, A_ALIGNED} align_st_e;

  localparam logic [7:0] COMMA_LIM = 8'(COMMA_COUNT);
  localparam logic [7:0] BAD_LIM   = 8'(BAD_CODE_LIMIT);
  localparam logic [7:0] GOOD_LIM  = 8'(GOOD_RUN);
  localparam logic [7:0] AL_LIM    = 8'(ALIGN_COUNT);
  localparam logic [7:0] ERR_LIM   = 8'(ALIGN_ERR_LIMIT);

  logic [63:0] data_q;
  logic [7:0]  k_q, v_q;
  logic [3:0]  berr_q;

  lane_st_e        lst_q [4];
  lane_st_e        lst_d [4];
  logic [3:0][7:0] ccnt_q, ccnt_d, cred_q, cred_d, run_q, run_d;

  align_st_e  ast_q, ast_d;
  logic [7:0] acnt_q, acnt_d, ecnt_q, ecnt_d;

  logic [3:0][1:0] comma_n;
  logic [1:0][3:0] a_slot;
  logic [3:0]      bad, lane_sync_d;
  logic [1:0]      al_n;
  logic            mis, all_sync, bad_synced, loss_evt;
  logic            chansync_q, link_up_q;
  logic [CNT_W-1:0] code_err_q, align_loss_q;

  always_comb begin
    comma_n = '0;
    a_slot  = '0;
    bad     = '0;
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 2; b++) begin
        if (k_q[l*2+b] && v_q[l*2+b]) begin
          if (data_q[l*16+b*8 +: 8] == 8'hBC) comma_n[l] = comma_n[l] + 2'd1;
          if (data_q[l*16+b*8 +: 8] == 8'h7C) a_slot[b][l] = 1'b1;
        end
      end
      bad[l] = ~&v_q[l*2 +: 2];
    end
  end

  always_comb begin
    bad_synced = 1'b0;
    for (int l = 0; l < 4; l++) begin
      lst_d[l]  = lst_q[l];
      ccnt_d[l] = ccnt_q[l];
      cred_d[l] = cred_q[l];
      run_d[l]  = run_q[l];
      case (lst_q[l])
        L_LOSS: begin
          // A bad byte anywhere in the cycle discards commas seen alongside it.
          if (bad[l])
            ccnt_d[l] = '0;
          else if (ccnt_q[l] + {6'd0, comma_n[l]} >= COMMA_LIM)
            ccnt_d[l] = COMMA_LIM;
          else
            ccnt_d[l] = ccnt_q[l] + {6'd0, comma_n[l]};
          if (ccnt_d[l] >= COMMA_LIM) begin
            lst_d[l]  = L_SYNC;
            cred_d[l] = '0;
            run_d[l]  = '0;
          end
        end
        L_SYNC: begin
          if (bad[l]) begin
            cred_d[l]  = cred_q[l] + 8'd1;
            run_d[l]   = '0;
            bad_synced = 1'b1;
          end else begin
            if (run_q[l] < GOOD_LIM) run_d[l] = run_q[l] + 8'd1;
            if (run_d[l] == GOOD_LIM && cred_q[l] != 8'd0) begin
              cred_d[l] = cred_q[l] - 8'd1;
              run_d[l]  = '0;
            end
          end
          if (cred_d[l] >= BAD_LIM) begin
            lst_d[l]  = L_LOSS;
            ccnt_d[l] = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_sync[l]   = (lst_q[l] == L_SYNC);
      lane_sync_d[l] = (lst_d[l] == L_SYNC);
    end
  end

  assign all_sync = &lane_sync;
  assign al_n     = {1'b0, &a_slot[0]} + {1'b0, &a_slot[1]};
  assign mis      = (|a_slot[0] & ~&a_slot[0]) | (|a_slot[1] & ~&a_slot[1]);

  always_comb begin
    ast_d    = ast_q;
    acnt_d   = acnt_q;
    ecnt_d   = ecnt_q;
    loss_evt = 1'b0;
    case (ast_q)
      A_LOSS: begin
        if (mis || !all_sync)
          acnt_d = '0;
        else if (acnt_q + {6'd0, al_n} >= AL_LIM)
          acnt_d = AL_LIM;
        else
          acnt_d = acnt_q + {6'd0, al_n};
        if (acnt_d >= AL_LIM) begin
          ast_d  = A_ALIGNED;
          ecnt_d = '0;
        end
      end
      A_ALIGNED: begin
        if (mis)
          ecnt_d = (ecnt_q >= ERR_LIM) ? ecnt_q : ecnt_q + 8'd1;
        else if (al_n != 2'd0)
          ecnt_d = '0;
        if (ecnt_d >= ERR_LIM || !all_sync || |berr_q) begin
          ast_d    = A_LOSS;
          acnt_d   = '0;
          loss_evt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge xaui_clk or negedge xaui_rst_n) begin
    if (!xaui_rst_n) begin
      data_q       <= '0;
      k_q          <= '0;
      v_q          <= '0;
      berr_q       <= '0;
      for (int l = 0; l < 4; l++) lst_q[l] <= L_LOSS;
      ccnt_q       <= '0;
      cred_q       <= '0;
      run_q        <= '0;
      ast_q        <= A_LOSS;
      acnt_q       <= '0;
      ecnt_q       <= '0;
      chansync_q   <= 1'b0;
      link_up_q    <= 1'b0;
      code_err_q   <= '0;
      align_loss_q <= '0;
    end else begin
      data_q     <= mgt_rxdata;
      k_q        <= mgt_rxcharisk;
      v_q        <= mgt_rxcodevalid;
      berr_q     <= mgt_rxbufferr;
      for (int l = 0; l < 4; l++) lst_q[l] <= lst_d[l];
      ccnt_q     <= ccnt_d;
      cred_q     <= cred_d;
      run_q      <= run_d;
      ast_q      <= ast_d;
      acnt_q     <= acnt_d;
      ecnt_q     <= ecnt_d;
      chansync_q <= (ast_d == A_LOSS) && (&lane_sync_d);
      link_up_q  <= (ast_d == A_ALIGNED) && (&lane_sync_d) && !(|berr_q);
      if (bad_synced && code_err_q != '1) code_err_q <= code_err_q + 1'b1;
      if (loss_evt && align_loss_q != '1) align_loss_q <= align_loss_q + 1'b1;
    end
  end

  assign mgt_rxencommaalign = ~lane_sync;
  assign mgt_rxenchansync   = chansync_q;
  assign align_status       = (ast_q == A_ALIGNED);
  assign link_up            = link_up_q;
  assign code_err_cnt       = code_err_q;
  assign align_loss_cnt     = align_loss_q;

endmodule

// File: tb/tb_xaui_rx_link_sync.sv
// Directed bench for xaui_rx_link_sync: lane sync, credit return, alignment, buffer error and reset.
module tb_xaui_rx_link_sync;

  logic        xaui_clk = 1'b0;
  logic        xaui_rst_n;
  logic [63:0] mgt_rxdata;
  logic [7:0]  mgt_rxcharisk, mgt_rxcodevalid;
  logic [3:0]  mgt_rxbufferr;
  logic [3:0]  mgt_rxencommaalign, lane_sync;
  logic        mgt_rxenchansync, align_status, link_up;
  logic [15:0] code_err_cnt, align_loss_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D_IDLE = 64'h0;
  localparam logic [63:0] D_L0C2 = 64'h0000_0000_0000_BCBC;
  localparam logic [63:0] D_L1C2 = 64'h0000_0000_BCBC_0000;
  localparam logic [63:0] D_L1C1 = 64'h0000_0000_00BC_0000;
  localparam logic [63:0] D_ALLC = 64'hBCBC_BCBC_BCBC_BCBC;
  localparam logic [63:0] D_ACOL = 64'h007C_007C_007C_007C;
  localparam logic [63:0] D_MCOL = 64'h0000_007C_007C_007C;

  xaui_rx_link_sync dut (
    .xaui_clk           (xaui_clk),
    .xaui_rst_n         (xaui_rst_n),
    .mgt_rxdata         (mgt_rxdata),
    .mgt_rxcharisk      (mgt_rxcharisk),
    .mgt_rxcodevalid    (mgt_rxcodevalid),
    .mgt_rxbufferr      (mgt_rxbufferr),
    .mgt_rxencommaalign (mgt_rxencommaalign),
    .mgt_rxenchansync   (mgt_rxenchansync),
    .lane_sync          (lane_sync),
    .align_status       (align_status),
    .link_up            (link_up),
    .code_err_cnt       (code_err_cnt),
    .align_loss_cnt     (align_loss_cnt)
  );

  always #5 xaui_clk = ~xaui_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] k, input logic [7:0] v,
                      input logic [3:0] be);
    mgt_rxdata      = d;
    mgt_rxcharisk   = k;
    mgt_rxcodevalid = v;
    mgt_rxbufferr   = be;
    @(posedge xaui_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(D_IDLE, 8'h00, 8'hFF, 4'h0);
  endtask

  task automatic acol(input int n);
    for (int i = 0; i < n; i++) step(D_ACOL, 8'h55, 8'hFF, 4'h0);
  endtask

  initial begin
    xaui_rst_n = 1'b0;
    mgt_rxdata = '0; mgt_rxcharisk = '0; mgt_rxcodevalid = 8'hFF; mgt_rxbufferr = '0;
    repeat (3) @(posedge xaui_clk);
    #1;
    check("rst_encomma", 32'(mgt_rxencommaalign), 32'hF);
    check("rst_lane_sync", 32'(lane_sync), 32'h0);
    check("rst_align", 32'(align_status), 32'h0);
    check("rst_chansync", 32'(mgt_rxenchansync), 32'h0);
    check("rst_link_up", 32'(link_up), 32'h0);
    check("rst_code_err", 32'(code_err_cnt), 32'h0);
    check("rst_align_loss", 32'(align_loss_cnt), 32'h0);
    @(negedge xaui_clk);
    xaui_rst_n = 1'b1;
    idle(2);

    // Lane 0: four commas over two cycles.
    step(D_L0C2, 8'h03, 8'hFF, 4'h0);
    step(D_L0C2, 8'h03, 8'hFF, 4'h0);
    check("t1_not_yet", 32'(lane_sync), 32'h0);
    idle(1);
    check("t1_lane_sync", 32'(lane_sync), 32'h1);
    check("t1_encomma", 32'(mgt_rxencommaalign), 32'hE);

    // Lane 1: 3 commas, bad code, 3 commas, then the 4th.
    step(D_L1C2, 8'h0C, 8'hFF, 4'h0);
    step(D_L1C1, 8'h04, 8'hFF, 4'h0);
    step(D_IDLE, 8'h00, 8'hFB, 4'h0);
    step(D_L1C2, 8'h0C, 8'hFF, 4'h0);
    step(D_L1C1, 8'h04, 8'hFF, 4'h0);
    idle(2);
    check("t2_stays_loss", 32'(lane_sync), 32'h1);
    step(D_L1C1, 8'h04, 8'hFF, 4'h0);
    idle(1);
    check("t2_lane1_sync", 32'(lane_sync), 32'h3);
    check("t2_code_err", 32'(code_err_cnt), 32'h0);

    step(D_ALLC, 8'hFF, 8'hFF, 4'h0);
    step(D_ALLC, 8'hFF, 8'hFF, 4'h0);
    idle(1);
    check("all_sync", 32'(lane_sync), 32'hF);
    check("chansync_on", 32'(mgt_rxenchansync), 32'h1);
    check("pre_align", 32'(align_status), 32'h0);
    check("pre_link_up", 32'(link_up), 32'h0);

    // Alignment on four ||A|| columns at byte slot 0.
    acol(4);
    check("t4_three_cols", 32'(align_status), 32'h0);
    idle(1);
    check("t4_align", 32'(align_status), 32'h1);
    check("t4_chansync_off", 32'(mgt_rxenchansync), 32'h0);
    check("t4_link_up", 32'(link_up), 32'h1);

    // Misaligned columns separated by an aligned column do not accumulate.
    step(D_MCOL, 8'h15, 8'hFF, 4'h0);
    idle(1);
    acol(1);
    idle(1);
    step(D_MCOL, 8'h15, 8'hFF, 4'h0);
    idle(2);
    check("t5_stay_aligned", 32'(align_status), 32'h1);
    acol(1);
    step(D_MCOL, 8'h15, 8'hFF, 4'h0);
    step(D_MCOL, 8'h15, 8'hFF, 4'h0);
    idle(2);
    check("t5_lost", 32'(align_status), 32'h0);
    check("t5_loss_cnt", 32'(align_loss_cnt), 32'h1);
    check("t5_link_down", 32'(link_up), 32'h0);
    check("t5_chansync", 32'(mgt_rxenchansync), 32'h1);

    acol(4);
    idle(1);
    check("realign1", 32'(align_status), 32'h1);
    check("realign1_link", 32'(link_up), 32'h1);

    // One-cycle elastic buffer error on lane 2.
    step(D_IDLE, 8'h00, 8'hFF, 4'b0100);
    idle(1);
    check("t6_link_down", 32'(link_up), 32'h0);
    check("t6_align_lost", 32'(align_status), 32'h0);
    check("t6_loss_cnt", 32'(align_loss_cnt), 32'h2);
    check("t6_lanes_kept", 32'(lane_sync), 32'hF);

    acol(4);
    idle(1);
    check("realign2", 32'(align_status), 32'h1);

    // Each bad cycle followed by exactly GOOD_RUN clean cycles returns its credit.
    for (int i = 0; i < 4; i++) begin
      step(D_IDLE, 8'h00, 8'hFE, 4'h0);
      idle(4);
    end
    idle(1);
    check("credit_return_sync", 32'(lane_sync), 32'hF);
    check("credit_return_err", 32'(code_err_cnt), 32'h4);
    check("credit_return_align", 32'(align_status), 32'h1);

    // Four bad cycles with too few clean cycles in between.
    for (int i = 0; i < 3; i++) begin
      step(D_IDLE, 8'h00, 8'hFE, 4'h0);
      idle(1);
    end
    check("t3_three_bad", 32'(lane_sync), 32'hF);
    step(D_IDLE, 8'h00, 8'hFE, 4'h0);
    idle(2);
    check("t3_lane_lost", 32'(lane_sync), 32'hE);
    check("t3_encomma", 32'(mgt_rxencommaalign), 32'h1);
    check("t3_code_err", 32'(code_err_cnt), 32'h8);
    check("t3_align_lost", 32'(align_status), 32'h0);
    check("t3_loss_cnt", 32'(align_loss_cnt), 32'h3);
    check("t3_link_down", 32'(link_up), 32'h0);

    // Mid-operation reset with partial comma count on lane 0.
    step(D_L0C2, 8'h03, 8'hFF, 4'h0);
    idle(1);
    xaui_rst_n = 1'b0;
    #1;
    check("mrst_encomma", 32'(mgt_rxencommaalign), 32'hF);
    check("mrst_lane_sync", 32'(lane_sync), 32'h0);
    check("mrst_code_err", 32'(code_err_cnt), 32'h0);
    check("mrst_loss_cnt", 32'(align_loss_cnt), 32'h0);
    check("mrst_chansync", 32'(mgt_rxenchansync), 32'h0);
    @(negedge xaui_clk);
    xaui_rst_n = 1'b1;
    idle(1);
    step(D_L0C2, 8'h03, 8'hFF, 4'h0);
    idle(2);
    check("mrst_no_credit", 32'(lane_sync), 32'h0);
    step(D_L0C2, 8'h03, 8'hFF, 4'h0);
    idle(1);
    check("mrst_resync", 32'(lane_sync), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
